// File: rtl/alu_add_sequencer.sv
// Operand sequencer and result/flag register around the external 8-bit ripple-carry adder.
// Collects A then B on data_in, conditions B and the carry-in for the selected operation, and registers sum and flags.
//
//  state  | meaning
//  -------+-----------------------------------------------------------
//  WAIT_A | idle, waiting for load to capture operand A
//  WAIT_B | A held, waiting for load to capture operand B and mode
//  EXEC   | adder settling on conditioned operands, result captured at exit
module alu_add_sequencer (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] data_in,
  input  logic       load,
  input  logic [1:0] mode,
  output logic [7:0] add_a,
  output logic [7:0] add_b,
  output logic       add_cin,
  input  logic [7:0] add_s,
  input  logic       add_cout,
  output logic [7:0] result,
  output logic       carry_flag,
  output logic       zero_flag,
  output logic       neg_flag,
  output logic       ovf_flag,
  output logic       busy,
  output logic       valid
);

  typedef enum logic [1:0] {
    WAIT_A = 2'd0,
    WAIT_B = 2'd1,
    EXEC   = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] reg_a_q, reg_a_d;
  logic [7:0] reg_b_q, reg_b_d;
  logic [1:0] reg_mode_q, reg_mode_d;
  logic [7:0] result_q, result_d;
  logic       carry_q, carry_d;
  logic       zero_q, zero_d;
  logic       neg_q, neg_d;
  logic       ovf_q, ovf_d;
  logic       busy_q, busy_d;
  logic       valid_q, valid_d;

  // SUB/SBB invert B; carry-in comes from the stored flag, never from add_cout.
  assign add_a   = reg_a_q;
  assign add_b   = reg_mode_q[1] ? ~reg_b_q : reg_b_q;
  assign add_cin = reg_mode_q[0] ? carry_q : reg_mode_q[1];

  always_comb begin
    state_d    = state_q;
    reg_a_d    = reg_a_q;
    reg_b_d    = reg_b_q;
    reg_mode_d = reg_mode_q;
    result_d   = result_q;
    carry_d    = carry_q;
    zero_d     = zero_q;
    neg_d      = neg_q;
    ovf_d      = ovf_q;
    busy_d     = 1'b0;
    valid_d    = 1'b0;
    case (state_q)
      WAIT_A: begin
        if (load) begin
          reg_a_d = data_in;
          state_d = WAIT_B;
        end
      end
      WAIT_B: begin
        if (load) begin
          reg_b_d    = data_in;
          reg_mode_d = mode;
          busy_d     = 1'b1;
          state_d    = EXEC;
        end
      end
      EXEC: begin
        result_d = add_s;
        carry_d  = add_cout;
        zero_d   = (add_s == 8'h00);
        neg_d    = add_s[7];
        ovf_d    = (add_a[7] == add_b[7]) && (add_s[7] != add_a[7]);
        valid_d  = 1'b1;
        state_d  = WAIT_A;
      end
      default: state_d = WAIT_A;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= WAIT_A;
      reg_a_q    <= 8'h00;
      reg_b_q    <= 8'h00;
      reg_mode_q <= 2'b00;
      result_q   <= 8'h00;
      carry_q    <= 1'b0;
      zero_q     <= 1'b0;
      neg_q      <= 1'b0;
      ovf_q      <= 1'b0;
      busy_q     <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      reg_a_q    <= reg_a_d;
      reg_b_q    <= reg_b_d;
      reg_mode_q <= reg_mode_d;
      result_q   <= result_d;
      carry_q    <= carry_d;
      zero_q     <= zero_d;
      neg_q      <= neg_d;
      ovf_q      <= ovf_d;
      busy_q     <= busy_d;
      valid_q    <= valid_d;
    end
  end

  assign result     = result_q;
  assign carry_flag = carry_q;
  assign zero_flag  = zero_q;
  assign neg_flag   = neg_q;
  assign ovf_flag   = ovf_q;
  assign busy       = busy_q;
  assign valid      = valid_q;

endmodule
